key_debounce_multi: RTL and testbench
=====================================

// Module: key_debounce_multi
// PURPOSE
//   Parametrised N-channel debouncer and press counter for active-low push keys.
//   Each channel has its own synchroniser, debounce FSM, debounced level, and press/release strobes.
//   It also keeps a wrapping per-key press counter with synchronous clear.
//   Sits between board key pins and control logic (mode select, LED/display counters).
// PARAMETERS
//   NUM_KEYS     4           number of independent key channels (>=1)
//   CLK_FREQ_HZ  50_000_000  clk frequency in Hz
//   DEBOUNCE_MS  20          stable time required for press and for release
//   CNT_W        8           width of each per-key press counter
//   LONG_MS      1000        long-press threshold (used only with KEY_LONGPRESS_EN)
//   Derived: DB_CYC = CLK_FREQ_HZ/1000*DEBOUNCE_MS; LONG_CYC = CLK_FREQ_HZ/1000*LONG_MS.
//   Elaboration error if DB_CYC < 2.
// PORTS
//   clk            in   1               system clock, all logic on rising edge
//   rst_n          in   1               asynchronous reset, active-low
//   key_in         in   NUM_KEYS        raw key pins, 0 = pressed; asynchronous to clk
//   cnt_clr        in   NUM_KEYS        synchronous clear of press_cnt[k]
//   key_level      out  NUM_KEYS        debounced state, 1 = pressed
//   press_pulse    out  NUM_KEYS        1-cycle strobe on each debounced press
//   release_pulse  out  NUM_KEYS        1-cycle strobe on each debounced release
//   press_cnt      out  NUM_KEYS*CNT_W  key k count at [k*CNT_W +: CNT_W]
//   long_pulse     out  NUM_KEYS        1-cycle strobe at long-press threshold
// BEHAVIOUR
//   - Reset: synchroniser flops <= 1; FSM IDLE; debounce/long counters 0.
//     All outputs 0, including press_cnt.
//   - Synchroniser: 2 flops per channel; FSM sees only the synced signal s[k].
//   - FSM per channel, states IDLE, PRESS_CHK, HELD, REL_CHK:
//     IDLE: s=0 -> PRESS_CHK, counter <= 0.
//     PRESS_CHK: s=0 -> counter+1.
//       s=1 before counter==DB_CYC-1 -> IDLE, counter <= 0 (bounce rejected).
//       counter==DB_CYC-1 with s=0 -> HELD; press_pulse=1 and key_level=1 registered on HELD entry.
//     HELD: s=1 -> REL_CHK, counter <= 0.
//     REL_CHK: s=1 -> counter+1.
//       s=0 before DB_CYC-1 -> HELD, no pulses.
//       counter==DB_CYC-1 with s=1 -> IDLE; release_pulse=1 and key_level=0 registered.
//   - Latency: key_in held low from edge E -> press_pulse high on edge E+DB_CYC+3
//     (2 synchroniser cycles, 1 IDLE cycle, DB_CYC cycles in PRESS_CHK).
//     Release path has identical latency.
//   - Strobes are exactly one cycle wide; at most one press_pulse per debounced press.
//   - press_cnt[k] increments by 1 on press_pulse[k]; wraps 2^CNT_W-1 -> 0 silently.
//     cnt_clr[k] zeroes it next cycle.
//     cnt_clr and press_pulse in the same cycle: clear wins and that press is not counted.
//   - Channels are fully independent; simultaneous presses on several keys all count.
//   - Reset mid-debounce: all progress discarded. A key still low after rst_n rises
//     is a new press: press_pulse at DB_CYC+3 after first sampled edge.
//   - Counter widths: $clog2(DB_CYC) and $clog2(LONG_CYC+1); no overflow is possible.
// CONFIGURATION
//   KEY_LONGPRESS_EN defined:
//     - Per-channel long counter runs in HELD and REL_CHK; reset to 0 on entry to IDLE.
//     - At LONG_CYC cycles after HELD entry: long_pulse[k]=1 for 1 cycle.
//     - long_pulse fires at most once per press; counter saturates afterwards.
//     - Release before the threshold produces no long_pulse.
//   KEY_LONGPRESS_EN undefined: long_pulse tied to 0; no long counters synthesised.
//     Port list is unchanged.
// TESTING  (bench: CLK_FREQ_HZ=1000, DEBOUNCE_MS=5 -> DB_CYC=5; LONG_MS=20 -> LONG_CYC=20;
//           NUM_KEYS=4, CNT_W=3)
//   1. key_in[0] low at edge 10, held -> press_pulse[0] high only on edge 18.
//      key_level[0]=1 from edge 18; press_cnt[0]=1.
//   2. key_in[1] low pulses of 3 cycles with 2-cycle highs, repeated 10 times
//      -> no press_pulse, press_cnt[1]=0.
//   3. Release key 0 with a 2-cycle relow bounce, then stable high
//      -> single release_pulse[0], DB_CYC+3 edges after the final rise.
//   4. 9 clean presses on key 2 -> press_cnt[2] wraps to 1.
//      Assert cnt_clr[2] on the cycle of press_pulse -> press_cnt[2]=0.
//   5. Keys 0 and 3 pressed on the same edge -> both press_pulses on the same edge,
//      and both counters increment.
//   6. rst_n low for 3 cycles during PRESS_CHK -> all outputs 0.
//      Key still low -> press_pulse DB_CYC+3 edges after rst_n rises.
//      With KEY_LONGPRESS_EN, hold 30 cycles -> one long_pulse 20 cycles after press_pulse.

Source files
------------

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N-channel debouncer and press counter for active-low push keys.
// Latency: a key edge appears on press_pulse/release_pulse DB_CYC+3 clocks after it is applied.
// Backpressure: none; strobes are single-cycle and consumers must sample them every cycle.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   key_in         raw key pins, 0 = pressed, asynchronous to clk
//   cnt_clr        synchronous clear of the matching press counter
//   key_level      debounced key state, 1 = pressed
//   press_pulse    1-cycle strobe on each debounced press
//   release_pulse  1-cycle strobe on each debounced release
//   press_cnt      wrapping per-key press counters, key k at [k*CNT_W +: CNT_W]
//   long_pulse     1-cycle strobe LONG_CYC cycles into a press (only when KEY_LONGPRESS_EN is defined)
//
// Optional feature macro: KEY_LONGPRESS_EN (long-press detection); when undefined long_pulse is 0.
module key_debounce_multi #(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int CNT_W       = 8,
  parameter int LONG_MS     = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_KEYS-1:0]       key_in,
  input  logic [NUM_KEYS-1:0]       cnt_clr,
  output logic [NUM_KEYS-1:0]       key_level,
  output logic [NUM_KEYS-1:0]       press_pulse,
  output logic [NUM_KEYS-1:0]       release_pulse,
  output logic [NUM_KEYS*CNT_W-1:0] press_cnt,
  output logic [NUM_KEYS-1:0]       long_pulse
);

  localparam int DB_CYC   = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYC = CLK_FREQ_HZ / 1000 * LONG_MS;
  localparam int DB_W     = (DB_CYC < 2) ? 1 : $clog2(DB_CYC);

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYC - 1);
  localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (DB_CYC < 2) begin : g_db_check
    $error("key_debounce_multi: debounce window must be at least 2 clock cycles");
  end
  if (LONG_CYC < 1) begin : g_long_check
    $error("key_debounce_multi: long-press threshold must be at least 1 clock cycle");
  end

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  // Two-flop synchronisers; idle level is 1 (key released).
  logic [NUM_KEYS-1:0]       r_sync1;
  logic [NUM_KEYS-1:0]       r_sync2;

  state_t                    r_state     [NUM_KEYS];
  state_t                    w_state_nxt [NUM_KEYS];
  logic [DB_W-1:0]           r_db_cnt    [NUM_KEYS];
  logic [DB_W-1:0]           w_db_cnt_nxt[NUM_KEYS];
  logic [NUM_KEYS-1:0]       w_press_set;
  logic [NUM_KEYS-1:0]       w_release_set;

  logic [NUM_KEYS-1:0]       r_key_level;
  logic [NUM_KEYS-1:0]       r_press_pulse;
  logic [NUM_KEYS-1:0]       r_release_pulse;
  logic [NUM_KEYS*CNT_W-1:0] r_press_cnt;

  // Next-state logic. The synced level is 1 when released, 0 when pressed.
  always_comb begin
    w_press_set   = '0;
    w_release_set = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_state_nxt[k]  = r_state[k];
      w_db_cnt_nxt[k] = r_db_cnt[k];
      case (r_state[k])
        IDLE: begin
          if (!r_sync2[k]) begin
            w_state_nxt[k]  = PRESS_CHK;
            w_db_cnt_nxt[k] = '0;
          end
        end
        PRESS_CHK: begin
          if (r_sync2[k]) begin
            w_state_nxt[k]  = IDLE;
            w_db_cnt_nxt[k] = '0;
          end else if (r_db_cnt[k] == DB_LAST) begin
            w_state_nxt[k]  = HELD;
            w_db_cnt_nxt[k] = '0;
            w_press_set[k]  = 1'b1;
          end else begin
            w_db_cnt_nxt[k] = r_db_cnt[k] + DB_ONE;
          end
        end
        HELD: begin
          if (r_sync2[k]) begin
            w_state_nxt[k]  = REL_CHK;
            w_db_cnt_nxt[k] = '0;
          end
        end
        REL_CHK: begin
          if (!r_sync2[k]) begin
            w_state_nxt[k]  = HELD;
            w_db_cnt_nxt[k] = '0;
          end else if (r_db_cnt[k] == DB_LAST) begin
            w_state_nxt[k]    = IDLE;
            w_db_cnt_nxt[k]   = '0;
            w_release_set[k]  = 1'b1;
          end else begin
            w_db_cnt_nxt[k] = r_db_cnt[k] + DB_ONE;
          end
        end
        default: begin
          w_state_nxt[k]  = IDLE;
          w_db_cnt_nxt[k] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1         <= '1;
      r_sync2         <= '1;
      r_key_level     <= '0;
      r_press_pulse   <= '0;
      r_release_pulse <= '0;
      r_press_cnt     <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_state[k]  <= IDLE;
        r_db_cnt[k] <= '0;
      end
    end else begin
      r_sync1         <= key_in;
      r_sync2         <= r_sync1;
      r_press_pulse   <= w_press_set;
      r_release_pulse <= w_release_set;
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_state[k]  <= w_state_nxt[k];
        r_db_cnt[k] <= w_db_cnt_nxt[k];
        if (w_press_set[k]) begin
          r_key_level[k] <= 1'b1;
        end else if (w_release_set[k]) begin
          r_key_level[k] <= 1'b0;
        end
        // Counter follows the visible strobe, so a clear raised while the
        // strobe is high suppresses that press.
        if (cnt_clr[k]) begin
          r_press_cnt[k*CNT_W +: CNT_W] <= '0;
        end else if (r_press_pulse[k]) begin
          r_press_cnt[k*CNT_W +: CNT_W] <= r_press_cnt[k*CNT_W +: CNT_W] + CNT_ONE;
        end
      end
    end
  end

  assign key_level     = r_key_level;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign press_cnt     = r_press_cnt;

`ifdef KEY_LONGPRESS_EN
  localparam int LONG_W = $clog2(LONG_CYC + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_FULL = LONG_W'(LONG_CYC);
  localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

  logic [LONG_W-1:0]   r_long_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_long_pulse;

  // Counts held cycles from HELD entry; saturates at the threshold so the
  // strobe fires only once per press. Cleared whenever the channel goes idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_long_pulse <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_long_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_long_pulse[k] <= 1'b0;
        if (w_state_nxt[k] == IDLE) begin
          r_long_cnt[k] <= '0;
        end else if (r_state[k] == HELD || r_state[k] == REL_CHK) begin
          if (r_long_cnt[k] != LONG_FULL) begin
            r_long_cnt[k] <= r_long_cnt[k] + LONG_ONE;
          end
          if (r_long_cnt[k] == LONG_LAST) begin
            r_long_pulse[k] <= 1'b1;
          end
        end
      end
    end
  end

  assign long_pulse = r_long_pulse;
`else
  assign long_pulse = '0;
`endif

endmodule

// File: tb/tb_key_debounce_multi.sv
`timescale 1ns/1ps
module tb_key_debounce_multi;

  localparam int NK   = 4;
  localparam int CW   = 3;
  localparam int DB   = 5;
  localparam int LAT  = DB + 3;
  localparam int LONG = 20;

  localparam int EV_PRESS = 0;
  localparam int EV_REL   = 1;
  localparam int EV_LONG  = 2;

  localparam int PR_LEVEL = 0;
  localparam int PR_CNT   = 1;
  localparam int PR_ZERO  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NK-1:0]   key_in = '1;
  logic [NK-1:0]   cnt_clr = '0;
  logic [NK-1:0]   key_level;
  logic [NK-1:0]   press_pulse;
  logic [NK-1:0]   release_pulse;
  logic [NK*CW-1:0] press_cnt;
  logic [NK-1:0]   long_pulse;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {int kind; int key; int cyc;} ev_t;
  typedef struct {int cyc; int kind; int key; int val;} probe_t;

  ev_t    ev_q[$];
  probe_t pr_q[$];

  key_debounce_multi #(
    .NUM_KEYS   (NK),
    .CLK_FREQ_HZ(1000),
    .DEBOUNCE_MS(5),
    .CNT_W      (CW),
    .LONG_MS    (20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .cnt_clr      (cnt_clr),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_cnt    (press_cnt),
    .long_pulse   (long_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string ev_name(input int kind);
    if (kind == EV_PRESS) return "press";
    if (kind == EV_REL)   return "release";
    return "long";
  endfunction

  function automatic string pr_name(input int kind);
    if (kind == PR_LEVEL) return "level";
    if (kind == PR_CNT)   return "count";
    return "reset_zero";
  endfunction

  task automatic check(input string name, input int key, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s key=%0d cyc=%0d actual=%0d required=%0d", name, key, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int kind, input int key, input int c);
    ev_q.push_back('{kind, key, c});
  endtask

  task automatic probe(input int c, input int kind, input int key, input int val);
    pr_q.push_back('{c, kind, key, val});
  endtask

  // Monitor: matches every observed strobe against the expected-event queue
  // and evaluates value probes scheduled for the current cycle.
  always @(negedge clk) begin
    for (int kind = 0; kind < 3; kind++) begin
      for (int k = 0; k < NK; k++) begin
        logic hit;
        int   idx;
        hit = (kind == EV_PRESS) ? press_pulse[k] :
              (kind == EV_REL)   ? release_pulse[k] : long_pulse[k];
        if (hit) begin
          idx = -1;
          for (int i = 0; i < ev_q.size(); i++)
            if (idx < 0 && ev_q[i].kind == kind && ev_q[i].key == k) idx = i;
          if (idx < 0) begin
            check({ev_name(kind), "_unexpected"}, k, cyc, -1);
          end else begin
            check({ev_name(kind), "_edge"}, k, cyc, ev_q[idx].cyc);
            ev_q.delete(idx);
          end
        end
      end
    end
    for (int i = ev_q.size() - 1; i >= 0; i--) begin
      if (ev_q[i].cyc < cyc) begin
        check({ev_name(ev_q[i].kind), "_missed"}, ev_q[i].key, -1, ev_q[i].cyc);
        ev_q.delete(i);
      end
    end
    for (int i = pr_q.size() - 1; i >= 0; i--) begin
      if (pr_q[i].cyc == cyc) begin
        int act;
        case (pr_q[i].kind)
          PR_LEVEL: act = int'(key_level[pr_q[i].key]);
          PR_CNT:   act = int'(press_cnt[pr_q[i].key*CW +: CW]);
          default:  act = int'({key_level, press_pulse, release_pulse, long_pulse, press_cnt});
        endcase
        check(pr_name(pr_q[i].kind), pr_q[i].key, act, pr_q[i].val);
        pr_q.delete(i);
      end
    end
  end

  initial begin
    int e;
    // Reset state
    tick(2);
    probe(cyc, PR_ZERO, 0, 0);
    tick(1);
    rst_n = 1'b1;
    tick(3);

    // 1: clean press on key 0, held
    e = cyc;
    key_in[0] = 1'b0;
    expect_ev(EV_PRESS, 0, e + LAT);
    probe(e + LAT - 1, PR_LEVEL, 0, 0);
    probe(e + LAT,     PR_LEVEL, 0, 1);
    probe(e + LAT + 2, PR_CNT,   0, 1);
`ifdef KEY_LONGPRESS_EN
    expect_ev(EV_LONG, 0, e + LAT + LONG);
`endif
    tick(12);

    // 2: key 1 bounces (3 low / 2 high) and is never accepted
    for (int r = 0; r < 10; r++) begin
      key_in[1] = 1'b0;
      tick(3);
      key_in[1] = 1'b1;
      tick(2);
    end
    tick(10);
    probe(cyc, PR_CNT,   1, 0);
    probe(cyc, PR_LEVEL, 1, 0);
    tick(1);

    // 3: release key 0 with a 2-cycle re-low bounce
    key_in[0] = 1'b1;
    tick(2);
    key_in[0] = 1'b0;
    tick(2);
    key_in[0] = 1'b1;
    e = cyc;
    expect_ev(EV_REL, 0, e + LAT);
    probe(e + LAT - 1, PR_LEVEL, 0, 1);
    probe(e + LAT,     PR_LEVEL, 0, 0);
    tick(12);

    // 4: nine presses on key 2 wrap the 3-bit counter to 1
    for (int p = 1; p <= 9; p++) begin
      e = cyc;
      key_in[2] = 1'b0;
      expect_ev(EV_PRESS, 2, e + LAT);
      tick(10);
      probe(cyc, PR_CNT, 2, p % 8);
      key_in[2] = 1'b1;
      e = cyc;
      expect_ev(EV_REL, 2, e + LAT);
      tick(11);
    end
    // clear raised while press_pulse is high wins over the increment
    e = cyc;
    key_in[2] = 1'b0;
    expect_ev(EV_PRESS, 2, e + LAT);
    tick(LAT);
    cnt_clr[2] = 1'b1;
    tick(1);
    cnt_clr[2] = 1'b0;
    probe(cyc,     PR_CNT, 2, 0);
    probe(cyc + 1, PR_CNT, 2, 0);
    tick(1);
    key_in[2] = 1'b1;
    e = cyc;
    expect_ev(EV_REL, 2, e + LAT);
    tick(11);

    // 5: keys 0 and 3 pressed on the same edge
    e = cyc;
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    expect_ev(EV_PRESS, 0, e + LAT);
    expect_ev(EV_PRESS, 3, e + LAT);
    probe(e + LAT + 2, PR_CNT, 0, 2);
    probe(e + LAT + 2, PR_CNT, 3, 1);
    tick(10);
    key_in[0] = 1'b1;
    key_in[3] = 1'b1;
    e = cyc;
    expect_ev(EV_REL, 0, e + LAT);
    expect_ev(EV_REL, 3, e + LAT);
    tick(11);

    // 6: reset during PRESS_CHK, key stays low and is re-detected
    key_in[1] = 1'b0;
    tick(4);
    rst_n = 1'b0;
    probe(cyc,     PR_ZERO, 0, 0);
    probe(cyc + 1, PR_ZERO, 0, 0);
    probe(cyc + 2, PR_ZERO, 0, 0);
    tick(3);
    rst_n = 1'b1;
    e = cyc;
    expect_ev(EV_PRESS, 1, e + LAT);
    probe(e + LAT + 2, PR_CNT, 1, 1);
`ifdef KEY_LONGPRESS_EN
    expect_ev(EV_LONG, 1, e + LAT + LONG);
`endif
    tick(LAT + 30);
    key_in[1] = 1'b1;
    expect_ev(EV_REL, 1, cyc + LAT);
    tick(12);

    tick(5);
    foreach (ev_q[i]) check({ev_name(ev_q[i].kind), "_never_seen"}, ev_q[i].key, -1, ev_q[i].cyc);
    foreach (pr_q[i]) check({pr_name(pr_q[i].kind), "_not_sampled"}, pr_q[i].key, -1, pr_q[i].cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
